// File: rtl/xadac_pkg.sv
// Shared xadac types: transaction ids and the dec/exe request/response payloads.
// Latency: none; this file only holds types and constants.
// Backpressure: none; flow control lives with the modules that use these types.
package xadac_pkg;

  localparam int SbLen = 16;
  localparam int IdW   = $clog2(SbLen);

  typedef logic [IdW-1:0] IdT;

  typedef struct packed {
    IdT          id;
    logic [31:0] instr;
  } DecReqT;

  typedef struct packed {
    IdT   id;
    logic accept;
  } DecRspT;

  typedef struct packed {
    IdT          id;
    logic [31:0] instr;
  } ExeReqT;

  typedef struct packed {
    IdT          id;
    logic [31:0] data;
  } ExeRspT;

endpackage

// File: rtl/xadac_if.sv
// xadac port bundle: dec and exe request/response channels with valid/ready.
// Latency: none; this is wiring only.
// Backpressure: each channel stalls while its valid is high and its ready is low.
interface xadac_if;
  import xadac_pkg::*;

  DecReqT dec_req;
  logic   dec_req_valid;
  logic   dec_req_ready;
  DecRspT dec_rsp;
  logic   dec_rsp_valid;
  logic   dec_rsp_ready;
  ExeReqT exe_req;
  logic   exe_req_valid;
  logic   exe_req_ready;
  ExeRspT exe_rsp;
  logic   exe_rsp_valid;
  logic   exe_rsp_ready;

  // The requesting side: drives requests and consumes responses.
  modport mst (
    output dec_req, dec_req_valid, input dec_req_ready,
    input  dec_rsp, dec_rsp_valid, output dec_rsp_ready,
    output exe_req, exe_req_valid, input exe_req_ready,
    input  exe_rsp, exe_rsp_valid, output exe_rsp_ready
  );

  // The serving side: consumes requests and drives responses.
  modport slv (
    input  dec_req, dec_req_valid, output dec_req_ready,
    output dec_rsp, dec_rsp_valid, input dec_rsp_ready,
    input  exe_req, exe_req_valid, output exe_req_ready,
    output exe_rsp, exe_rsp_valid, input exe_rsp_ready
  );

endinterface

// File: rtl/xadac_id_fifo.sv
// Synchronous id FIFO holding the issue order of in-flight exe transactions.
// Latency: a pushed id is visible at head the cycle after the push.
// Backpressure: push is ignored while full and pop while empty; callers gate on full/empty.
module xadac_id_fifo #(
  parameter int  Depth = 4,
  parameter type IdT   = logic [3:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  IdT                         push_id,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output IdT                         head,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth+1);

  IdT            mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/xadac_exe_rob.sv
// Exe-response reorder buffer: returns mux exe responses to the core in issue order.
// Latency: req path combinational; a buffered head response reaches the core one cycle after capture.
// Backpressure: req stalls when full or id already in flight; core rsp stall holds head; mux rsp always accepted.
module xadac_exe_rob
  import xadac_pkg::*;
#(
  parameter int Depth = SbLen
) (
  input  logic  clk,
  input  logic  rst,
  xadac_if.slv  slv,
  xadac_if.mst  mst,
  output logic  err
);

  localparam int CntW = $clog2(Depth+1);

  logic [CntW-1:0]  count;
  logic             fifo_full;
  logic             fifo_empty;
  IdT               head;
  logic [SbLen-1:0] inflight;
  logic [SbLen-1:0] slot_valid;
  ExeRspT           slot_data [SbLen];
  IdT               req_id;
  IdT               rsp_id;
  logic             can_alloc;
  logic             req_hs;
  logic             rsp_hs;
  logic             wr_ok;

  // Dec channels are untouched wires in both directions.
  assign mst.dec_req       = slv.dec_req;
  assign mst.dec_req_valid = slv.dec_req_valid;
  assign slv.dec_req_ready = mst.dec_req_ready;
  assign slv.dec_rsp       = mst.dec_rsp;
  assign slv.dec_rsp_valid = mst.dec_rsp_valid;
  assign mst.dec_rsp_ready = slv.dec_rsp_ready;

  // Allocation depends only on registered state, so core rsp_ready never reaches the req path.
  assign req_id    = slv.exe_req.id;
  assign can_alloc = (count < CntW'(Depth)) && !inflight[req_id];

  assign mst.exe_req       = slv.exe_req;
  assign mst.exe_req_valid = slv.exe_req_valid && can_alloc;
  assign slv.exe_req_ready = mst.exe_req_ready && can_alloc;
  assign req_hs            = slv.exe_req_valid && mst.exe_req_ready && can_alloc;

  // Mux responses are never stalled; a response for an unknown or already-filled id is dropped.
  assign mst.exe_rsp_ready = 1'b1;
  assign rsp_id            = mst.exe_rsp.id;
  assign wr_ok             = mst.exe_rsp_valid && inflight[rsp_id] && !slot_valid[rsp_id];

  // Only the oldest outstanding id may be returned; its slot is read straight from storage.
  assign slv.exe_rsp_valid = !fifo_empty && slot_valid[head];
  assign slv.exe_rsp       = slot_data[head];
  assign rsp_hs            = slv.exe_rsp_valid && slv.exe_rsp_ready;

  xadac_id_fifo #(
    .Depth (Depth),
    .IdT   (IdT)
  ) u_order (
    .clk     (clk),
    .rst     (rst),
    .push    (req_hs),
    .push_id (req_id),
    .pop     (rsp_hs),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head),
    .count   (count)
  );

  // Track in-flight ids and filled slots; retire, alloc and capture never touch the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= '0;
      slot_valid <= '0;
      err        <= 1'b0;
    end else begin
      if (rsp_hs) begin
        inflight[head]   <= 1'b0;
        slot_valid[head] <= 1'b0;
      end
      if (req_hs) inflight[req_id] <= 1'b1;
      if (wr_ok)  slot_valid[rsp_id] <= 1'b1;
      if (mst.exe_rsp_valid && !wr_ok) err <= 1'b1;
    end
  end

  // Response payload capture; validity is carried by slot_valid, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) slot_data[rsp_id] <= mst.exe_rsp;
  end

  // Allocation is only ever granted with room left in the order queue.
  assert property (@(posedge clk) disable iff (rst) req_hs |-> !fifo_full);

endmodule

// File: tb/tb_xadac_exe_rob.sv
// Bench for xadac_exe_rob: directed scenarios plus random traffic against an issue-order queue model.
// Latency: checks each cycle at the falling edge against the model state of the previous edge.
// Backpressure: randomizes mux req ready and core rsp ready; mux returns pending ids in random order.
module tb_xadac_exe_rob;
  import xadac_pkg::*;

  localparam int Depth = 4;

  logic clk = 1'b0;
  logic rst;
  logic err;

  always #5 clk = ~clk;

  xadac_if core_if();
  xadac_if mux_if();

  xadac_exe_rob #(.Depth(Depth)) dut (
    .clk (clk),
    .rst (rst),
    .slv (core_if.slv),
    .mst (mux_if.mst),
    .err (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: issue order as a queue of ids, plus the responses received so far.
  IdT     m_q[$];
  bit     m_have [SbLen];
  ExeRspT m_data [SbLen];
  bit     m_err;
  bit     m_last_acc;
  bit     chk_en;

  // Observations from the most recent falling edge, for directed checks.
  bit     obs_req_rdy;
  bit     obs_up_vld;
  IdT     obs_up_id;
  bit     obs_err;
  bit     prev_stall;
  ExeRspT prev_dat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_flight(input IdT id);
    foreach (m_q[i]) if (m_q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic rand_dec();
    core_if.dec_req       = '{id: IdT'($urandom_range(0, SbLen-1)), instr: $urandom()};
    core_if.dec_req_valid = 1'($urandom_range(0, 1));
    core_if.dec_rsp_ready = 1'($urandom_range(0, 1));
    mux_if.dec_req_ready  = 1'($urandom_range(0, 1));
    mux_if.dec_rsp        = '{id: IdT'($urandom_range(0, SbLen-1)), accept: 1'($urandom_range(0, 1))};
    mux_if.dec_rsp_valid  = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle: check outputs at negedge, advance the model at posedge, then settle.
  task automatic step();
    bit     alloc, upv, req_hs, pop;
    IdT     h;
    ExeRspT r;
    @(negedge clk);
    alloc = (m_q.size() < Depth) && !in_flight(core_if.exe_req.id);
    upv   = (m_q.size() != 0) && m_have[m_q[0]];
    obs_req_rdy = core_if.exe_req_ready;
    obs_up_vld  = core_if.exe_rsp_valid;
    obs_up_id   = core_if.exe_rsp.id;
    obs_err     = err;
    if (chk_en) begin
      chk("err", 64'(err), 64'(m_err));
      chk("up_vld", 64'(core_if.exe_rsp_valid), 64'(upv));
      if (upv) chk("up_dat", 64'(core_if.exe_rsp), 64'(m_data[m_q[0]]));
      chk("req_rdy", 64'(core_if.exe_req_ready), 64'(mux_if.exe_req_ready && alloc));
      chk("mst_req_vld", 64'(mux_if.exe_req_valid), 64'(core_if.exe_req_valid && alloc));
      if (core_if.exe_req_valid) chk("mst_req_dat", 64'(mux_if.exe_req), 64'(core_if.exe_req));
      chk("mst_rsp_rdy", 64'(mux_if.exe_rsp_ready), 64'd1);
      chk("dec_pass",
          64'({mux_if.dec_req, mux_if.dec_req_valid, core_if.dec_req_ready,
               core_if.dec_rsp, core_if.dec_rsp_valid, mux_if.dec_rsp_ready}),
          64'({core_if.dec_req, core_if.dec_req_valid, mux_if.dec_req_ready,
               mux_if.dec_rsp, mux_if.dec_rsp_valid, core_if.dec_rsp_ready}));
      if (prev_stall) begin
        chk("hold_vld", 64'(core_if.exe_rsp_valid), 64'd1);
        chk("hold_dat", 64'(core_if.exe_rsp), 64'(prev_dat));
      end
    end
    prev_stall = core_if.exe_rsp_valid && !core_if.exe_rsp_ready && !rst;
    prev_dat   = core_if.exe_rsp;
    req_hs = core_if.exe_req_valid && mux_if.exe_req_ready && alloc;
    pop    = upv && core_if.exe_rsp_ready;
    @(posedge clk);
    m_last_acc = 1'b0;
    if (rst) begin
      m_q.delete();
      foreach (m_have[i]) m_have[i] = 1'b0;
      m_err = 1'b0;
    end else begin
      if (mux_if.exe_rsp_valid) begin
        r = mux_if.exe_rsp;
        if (in_flight(r.id) && !m_have[r.id]) begin
          m_have[r.id] = 1'b1;
          m_data[r.id] = r;
        end else begin
          m_err = 1'b1;
        end
      end
      if (pop) begin
        h = m_q.pop_front();
        m_have[h] = 1'b0;
      end
      if (req_hs) begin
        m_q.push_back(core_if.exe_req.id);
        m_last_acc = 1'b1;
      end
    end
    #1;
    rand_dec();
  endtask

  task automatic issue(input int id);
    int n = 0;
    core_if.exe_req       = '{id: IdT'(id), instr: $urandom()};
    core_if.exe_req_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!m_last_acc && n < 40);
    chk($sformatf("issue_acc_%0d", id), 64'(m_last_acc), 64'd1);
    core_if.exe_req_valid = 1'b0;
  endtask

  task automatic respond(input int id);
    mux_if.exe_rsp       = '{id: IdT'(id), data: $urandom()};
    mux_if.exe_rsp_valid = 1'b1;
    step();
    mux_if.exe_rsp_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    core_if.exe_rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    IdT pend[$];
    rst                   = 1'b1;
    chk_en                = 1'b0;
    core_if.exe_req       = '0;
    core_if.exe_req_valid = 1'b0;
    core_if.exe_rsp_ready = 1'b1;
    mux_if.exe_req_ready  = 1'b1;
    mux_if.exe_rsp        = '0;
    mux_if.exe_rsp_valid  = 1'b0;
    rand_dec();
    m_err = 1'b0;
    foreach (m_have[i]) m_have[i] = 1'b0;

    // Reset
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    core_if.exe_req = '{id: IdT'(0), instr: 32'h0};
    step();
    chk("rst_up_vld", 64'(obs_up_vld), 64'd0);
    chk("rst_err", 64'(obs_err), 64'd0);
    chk("rst_req_rdy", 64'(obs_req_rdy), 64'd1);

    // In-order
    issue(3);
    issue(5);
    respond(3);
    respond(5);
    chk("inord_first", 64'(obs_up_id), 64'd3);
    step();
    chk("inord_second", 64'(obs_up_id), 64'd5);
    drain(2);
    chk("inord_err", 64'(obs_err), 64'd0);

    // Out-of-order
    issue(1); issue(2); issue(7);
    respond(7);
    respond(2);
    chk("ooo_hidden", 64'(obs_up_vld), 64'd0);
    respond(1);
    chk("ooo_hidden2", 64'(obs_up_vld), 64'd0);
    step(); chk("ooo_r1", 64'({obs_up_vld, obs_up_id}), 64'({1'b1, IdT'(1)}));
    step(); chk("ooo_r2", 64'({obs_up_vld, obs_up_id}), 64'({1'b1, IdT'(2)}));
    step(); chk("ooo_r3", 64'({obs_up_vld, obs_up_id}), 64'({1'b1, IdT'(7)}));
    drain(2);

    // Backpressure on the core response side
    issue(4);
    core_if.exe_rsp_ready = 1'b0;
    respond(4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_vld", 64'(obs_up_vld), 64'd1);
    end
    issue(6);
    respond(6);
    drain(4);

    // Full
    issue(10); issue(11); issue(12); issue(13);
    core_if.exe_req       = '{id: IdT'(14), instr: $urandom()};
    core_if.exe_req_valid = 1'b1;
    step();
    chk("full_stall", 64'(obs_req_rdy), 64'd0);
    respond(10);
    chk("full_stall2", 64'(obs_req_rdy), 64'd0);
    step();
    chk("full_pop_id", 64'({obs_up_vld, obs_up_id}), 64'({1'b1, IdT'(10)}));
    chk("full_pop_rdy", 64'(obs_req_rdy), 64'd0);
    step();
    chk("full_reaccept", 64'(obs_req_rdy), 64'd1);
    core_if.exe_req_valid = 1'b0;
    respond(13); respond(11); respond(14); respond(12);
    drain(6);

    // Duplicate id stalls until retired
    issue(2);
    core_if.exe_req       = '{id: IdT'(2), instr: $urandom()};
    core_if.exe_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dup_stall", 64'(obs_req_rdy), 64'd0);
    end
    respond(2);
    step();
    chk("dup_pop_rdy", 64'(obs_req_rdy), 64'd0);
    step();
    chk("dup_accept", 64'(obs_req_rdy), 64'd1);
    core_if.exe_req_valid = 1'b0;
    respond(2);
    drain(3);

    // Response for an id not in flight
    respond(9);
    step();
    chk("err_set", 64'(obs_err), 64'd1);
    drain(3);
    chk("err_held", 64'(obs_err), 64'd1);

    // Reset mid-operation
    issue(1); issue(2); issue(3);
    respond(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    core_if.exe_req       = '{id: IdT'(1), instr: $urandom()};
    core_if.exe_req_valid = 1'b1;
    step();
    chk("mrst_up_vld", 64'(obs_up_vld), 64'd0);
    chk("mrst_err", 64'(obs_err), 64'd0);
    chk("mrst_accept", 64'(obs_req_rdy), 64'd1);
    core_if.exe_req_valid = 1'b0;
    respond(1);
    drain(2);
    respond(3);
    step();
    chk("mrst_late_err", 64'(obs_err), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst                   = ($urandom_range(0, 299) == 0);
      core_if.exe_req       = '{id: IdT'($urandom_range(0, 7)), instr: $urandom()};
      core_if.exe_req_valid = ($urandom_range(0, 99) < 60);
      mux_if.exe_req_ready  = ($urandom_range(0, 99) < 80);
      core_if.exe_rsp_ready = ($urandom_range(0, 99) < 70);
      pend.delete();
      foreach (m_q[i]) if (!m_have[m_q[i]]) pend.push_back(m_q[i]);
      mux_if.exe_rsp_valid = 1'b0;
      if ($urandom_range(0, 99) == 0) begin
        mux_if.exe_rsp       = '{id: IdT'($urandom_range(0, SbLen-1)), data: $urandom()};
        mux_if.exe_rsp_valid = 1'b1;
      end else if (pend.size() != 0 && $urandom_range(0, 1) == 1) begin
        mux_if.exe_rsp       = '{id: pend[$urandom_range(0, pend.size()-1)], data: $urandom()};
        mux_if.exe_rsp_valid = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
